// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external ALU between two requesters,
// with a registered issue stage and one response slot per port.
module alu_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*OPW-1:0]  req_op,
    input  logic [2*XLEN-1:0] req_a,
    input  logic [2*XLEN-1:0] req_b,
    output logic [1:0]        resp_valid,
    input  logic [1:0]        resp_ready,
    output logic [2*XLEN-1:0] resp_data,
    output logic [OPW-1:0]    alu_op,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    input  logic [XLEN-1:0]   alu_result
);

    logic              iss_valid_q, iss_valid_d;
    logic              iss_owner_q, iss_owner_d;
    logic              last_grant_q, last_grant_d;
    logic [OPW-1:0]    alu_op_q, alu_op_d;
    logic [XLEN-1:0]   alu_a_q, alu_a_d;
    logic [XLEN-1:0]   alu_b_q, alu_b_d;
    logic [1:0]        resp_valid_q, resp_valid_d;
    logic [2*XLEN-1:0] resp_data_q, resp_data_d;

    logic [1:0] pop;
    logic       iss_drain;
    logic       iss_free;
    logic       grant;
    logic       accept;

    // Drain/free conditions and round-robin grant; no grant while in reset.
    always_comb begin
        pop       = resp_valid_q & resp_ready;
        iss_drain = iss_valid_q
                  & (~resp_valid_q[iss_owner_q] | pop[iss_owner_q]);
        iss_free  = ~iss_valid_q | iss_drain;
        grant     = (&req_valid) ? ~last_grant_q : req_valid[1];
        accept    = rst_n & iss_free & req_valid[grant];
        req_ready = 2'b00;
        req_ready[grant] = accept;
    end

    // Next state of the issue stage, grant pointer and response slots.
    always_comb begin
        iss_valid_d  = iss_valid_q;
        iss_owner_d  = iss_owner_q;
        last_grant_d = last_grant_q;
        alu_op_d     = alu_op_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;

        for (int i = 0; i < 2; i++) begin
            if (iss_drain && (iss_owner_q == 1'(i))) begin
                resp_valid_d[i] = 1'b1;
                resp_data_d[i*XLEN +: XLEN] = alu_result;
            end else if (pop[i]) begin
                resp_valid_d[i] = 1'b0;
            end
        end

        if (accept) begin
            iss_valid_d  = 1'b1;
            iss_owner_d  = grant;
            last_grant_d = grant;
            alu_op_d     = req_op[grant*OPW +: OPW];
            alu_a_d      = req_a[grant*XLEN +: XLEN];
            alu_b_d      = req_b[grant*XLEN +: XLEN];
        end else if (iss_free) begin
            iss_valid_d = 1'b0;
        end
    end

    // State registers; port 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q  <= 1'b0;
            iss_owner_q  <= 1'b0;
            last_grant_q <= 1'b1;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            resp_valid_q <= 2'b00;
            resp_data_q  <= '0;
        end else begin
            iss_valid_q  <= iss_valid_d;
            iss_owner_q  <= iss_owner_d;
            last_grant_q <= last_grant_d;
            alu_op_q     <= alu_op_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign alu_op     = alu_op_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;

endmodule
